// File: rtl/pixel_stream_fifo_if.sv
// Pixel stream bus: the incoming valid/ready pixel stream together with the
// LCD driver's per-pixel request/response channel.
`timescale 1ns/1ps
interface pixel_stream_fifo_if;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        s_sof;
    logic        pixel_request;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic [23:0] pixel_data;

    modport master (
        output s_valid, s_data, s_sof, pixel_request, pixel_x, pixel_y,
        input  s_ready, pixel_data
    );

    modport slave (
        input  s_valid, s_data, s_sof, pixel_request, pixel_x, pixel_y,
        output s_ready, pixel_data
    );
endinterface

// File: rtl/pixel_stream_fifo.sv
// Elastic pixel buffer between the decoded link stream and the LCD timing
// driver. Aligns stream frames to display frames (SEEK/FILL/LOCKED), serves
// one pixel per request with one cycle of latency, substitutes FILL_COLOR on
// underflow and resynchronises on frame-length mismatches.
`timescale 1ns/1ps
module pixel_stream_fifo #(
    parameter int          DEPTH      = 1024,
    parameter int          AW         = 10,
    parameter logic [23:0] FILL_COLOR = 24'h000000
) (
    input  logic                pclk,
    input  logic                rst,
    pixel_stream_fifo_if.slave  bus,
    output logic                locked,
    output logic [AW:0]         level,
    output logic [15:0]         underflow_cnt,
    output logic [7:0]          sync_err_cnt
);

    typedef enum logic [1:0] {SEEK, FILL, LOCKED} state_t;

    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    state_t        state;
    state_t        state_nxt;

    // Storage entries are {sof, rgb}; head_q mirrors mem[rd_ptr] at all times.
    logic [24:0]   mem [DEPTH];
    logic [24:0]   head_q;
    logic [24:0]   wdata;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;

    logic start;
    logic accept;
    logic empty;
    logic head_sof;
    logic wr_en;
    logic pop;
    logic flush;
    logic inc_under;
    logic inc_sync;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // In SEEK the buffer is always empty, so beats are always taken (and
    // mostly discarded); otherwise a full buffer stalls the stream even if a
    // pop happens in the same cycle.
    assign bus.s_ready = (state == SEEK) || (level != FULL_LEVEL);

    assign accept   = bus.s_valid && bus.s_ready;
    assign start    = bus.pixel_request && (bus.pixel_x == 11'd0) && (bus.pixel_y == 11'd0);
    assign empty    = (level == '0);
    assign head_sof = head_q[24];
    assign wdata    = {bus.s_sof, bus.s_data};

    // State register.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= SEEK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision: frame alignment and mismatch recovery.
    always_comb begin
        state_nxt = state;
        case (state)
            SEEK: begin
                if (accept && bus.s_sof) state_nxt = FILL;
            end
            FILL: begin
                if (start && !empty && head_sof) state_nxt = LOCKED;
            end
            LOCKED: begin
                if (bus.pixel_request && !empty) begin
                    if (start && !head_sof)      state_nxt = SEEK;  // stream frame too long
                    else if (!start && head_sof) state_nxt = FILL;  // stream frame too short
                end
            end
            default: state_nxt = SEEK;
        endcase
    end

    // Per-state datapath controls: write, pop, flush and error events.
    always_comb begin
        wr_en     = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        inc_under = 1'b0;
        inc_sync  = 1'b0;
        case (state)
            SEEK: begin
                wr_en = accept && bus.s_sof;
            end
            FILL: begin
                wr_en = accept;
                pop   = start && !empty && head_sof;
            end
            LOCKED: begin
                if (bus.pixel_request) begin
                    if (empty) begin
                        inc_under = 1'b1;
                    end else if (start == head_sof) begin
                        pop = 1'b1;
                    end else begin
                        inc_sync = 1'b1;
                        flush    = start;
                    end
                end
                // The beat accepted on the flush edge is dropped.
                wr_en = accept && !flush;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    assign rd_ptr_nxt = flush ? '0 : (pop ? rd_ptr + PTR_ONE : rd_ptr);

    // Pointers, occupancy, lock flag and saturating error counters.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            locked        <= 1'b0;
            underflow_cnt <= '0;
            sync_err_cnt  <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
                rd_ptr <= rd_ptr_nxt;
                if (wr_en && !pop)      level <= level + LVL_ONE;
                else if (!wr_en && pop) level <= level - LVL_ONE;
            end
            locked <= (state_nxt == LOCKED);
            if (inc_under) underflow_cnt <= sat_inc16(underflow_cnt);
            if (inc_sync)  sync_err_cnt  <= sat_inc8(sync_err_cnt);
        end
    end

    // Pixel storage write port.
    always_ff @(posedge pclk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    // Head prefetch: synchronous read at the next read address, with the
    // incoming beat forwarded when it lands in the slot becoming the head.
    always_ff @(posedge pclk) begin
        if (wr_en && (wr_ptr == rd_ptr_nxt)) head_q <= wdata;
        else                                 head_q <= mem[rd_ptr_nxt];
    end

    // Registered response: head pixel on a pop, fill colour otherwise; holds
    // between requests.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            bus.pixel_data <= FILL_COLOR;
        end else if (bus.pixel_request) begin
            bus.pixel_data <= pop ? head_q[23:0] : FILL_COLOR;
        end
    end

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Directed bench for pixel_stream_fifo: clean lock, pre-sof garbage,
// underflow, short/long frame recovery, full buffer and mid-operation reset.
`timescale 1ns/1ps
module tb_pixel_stream_fifo;

    localparam logic [23:0] FILL = 24'hABCDEF;

    logic        pclk;
    logic        rst;
    logic        locked;
    logic [10:0] level;
    logic [15:0] underflow_cnt;
    logic [7:0]  sync_err_cnt;
    int          checks;
    int          failures;

    pixel_stream_fifo_if bus ();

    pixel_stream_fifo #(
        .DEPTH      (1024),
        .AW         (10),
        .FILL_COLOR (FILL)
    ) dut (
        .pclk          (pclk),
        .rst           (rst),
        .bus           (bus),
        .locked        (locked),
        .level         (level),
        .underflow_cnt (underflow_cnt),
        .sync_err_cnt  (sync_err_cnt)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic send(input logic [23:0] d, input logic sof);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_sof   = sof;
        tick();
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    task automatic send_seq(input logic [23:0] base, input int n);
        for (int i = 0; i < n; i++) send(base + 24'(i), (i == 0));
    endtask

    task automatic req(input logic [10:0] x, input logic [10:0] y);
        bus.pixel_request = 1'b1;
        bus.pixel_x       = x;
        bus.pixel_y       = y;
        tick();
        bus.pixel_request = 1'b0;
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b1;
        bus.s_valid       = 1'b0;
        bus.s_data        = '0;
        bus.s_sof         = 1'b0;
        bus.pixel_request = 1'b0;
        bus.pixel_x       = '0;
        bus.pixel_y       = '0;

        // Reset values
        #1;
        check("rst_s_ready", 32'(bus.s_ready), 32'h1);
        tick();
        tick();
        rst = 1'b0;
        check("rst_pixel_data", 32'(bus.pixel_data), 32'(FILL));
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_underflow", 32'(underflow_cnt), 32'h0);
        check("rst_sync_err", 32'(sync_err_cnt), 32'h0);

        // Clean lock: 4x2 frame rgb 1..8
        send_seq(24'd1, 8);
        check("clean_level_full", 32'(level), 32'd8);
        check("clean_locked_pre", 32'(locked), 32'h0);
        for (int i = 0; i < 8; i++) begin
            req(11'(i % 4), 11'(i / 4));
            check("clean_pixel", 32'(bus.pixel_data), 32'(i + 1));
            if (i == 0) check("clean_locked", 32'(locked), 32'h1);
        end
        check("clean_level_end", 32'(level), 32'h0);
        check("clean_underflow", 32'(underflow_cnt), 32'h0);
        check("clean_sync_err", 32'(sync_err_cnt), 32'h0);
        tick();
        check("clean_hold", 32'(bus.pixel_data), 32'd8);

        // Pre-sof garbage is discarded in SEEK
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) send(24'h000055, 1'b0);
        check("garbage_level", 32'(level), 32'h0);
        send_seq(24'd1, 8);
        check("garbage_frame_level", 32'(level), 32'd8);
        for (int i = 0; i < 8; i++) begin
            req(11'(i % 4), 11'(i / 4));
            check("garbage_pixel", 32'(bus.pixel_data), 32'(i + 1));
        end
        check("garbage_locked", 32'(locked), 32'h1);

        // Underflow while locked with an empty buffer
        for (int k = 1; k <= 3; k++) begin
            req(11'd1, 11'd0);
            check("under_pixel", 32'(bus.pixel_data), 32'(FILL));
            check("under_cnt", 32'(underflow_cnt), 32'(k));
            check("under_locked", 32'(locked), 32'h1);
        end

        // Short frame: 6 pixels then the next frame's sof
        send_seq(24'h000010, 6);
        send_seq(24'h000020, 8);
        check("short_level", 32'(level), 32'd14);
        for (int i = 0; i < 6; i++) begin
            req(11'(i % 4), 11'(i / 4));
            check("short_pixel", 32'(bus.pixel_data), 32'h10 + 32'(i));
        end
        req(11'd2, 11'd1);
        check("short_err_pixel", 32'(bus.pixel_data), 32'(FILL));
        check("short_sync_err", 32'(sync_err_cnt), 32'h1);
        check("short_locked", 32'(locked), 32'h0);
        check("short_level_kept", 32'(level), 32'd8);
        req(11'd3, 11'd1);
        check("short_fill_pixel", 32'(bus.pixel_data), 32'(FILL));
        check("short_fill_level", 32'(level), 32'd8);
        req(11'd0, 11'd0);
        check("short_relock_pixel", 32'(bus.pixel_data), 32'h20);
        check("short_relock", 32'(locked), 32'h1);
        for (int i = 1; i < 8; i++) begin
            req(11'(i % 4), 11'(i / 4));
            check("short_next_pixel", 32'(bus.pixel_data), 32'h20 + 32'(i));
        end
        check("short_level_end", 32'(level), 32'h0);

        // Long frame: 10 pixels, second start lands on a non-sof head
        send_seq(24'h000030, 10);
        for (int i = 0; i < 8; i++) begin
            req(11'(i % 4), 11'(i / 4));
            check("long_pixel", 32'(bus.pixel_data), 32'h30 + 32'(i));
        end
        check("long_level_left", 32'(level), 32'd2);
        bus.s_valid       = 1'b1;
        bus.s_data        = 24'h000040;
        bus.s_sof         = 1'b1;
        bus.pixel_request = 1'b1;
        bus.pixel_x       = 11'd0;
        bus.pixel_y       = 11'd0;
        tick();
        bus.s_valid       = 1'b0;
        bus.s_sof         = 1'b0;
        bus.pixel_request = 1'b0;
        check("long_err_pixel", 32'(bus.pixel_data), 32'(FILL));
        check("long_sync_err", 32'(sync_err_cnt), 32'd2);
        check("long_level_flushed", 32'(level), 32'h0);
        check("long_locked", 32'(locked), 32'h0);
        check("long_s_ready", 32'(bus.s_ready), 32'h1);
        send(24'h000041, 1'b0);
        check("long_seek_discard", 32'(level), 32'h0);
        check("long_underflow_kept", 32'(underflow_cnt), 32'd3);

        // Full buffer with no requests
        send(24'h000100, 1'b1);
        for (int i = 1; i < 1024; i++) send(24'h000100 + 24'(i), 1'b0);
        check("full_level", 32'(level), 32'd1024);
        check("full_s_ready", 32'(bus.s_ready), 32'h0);
        send(24'h000EEE, 1'b0);
        check("full_extra_level", 32'(level), 32'd1024);

        // Mid-operation reset returns everything to reset values at once
        rst = 1'b1;
        #1;
        check("midrst_level", 32'(level), 32'h0);
        check("midrst_s_ready", 32'(bus.s_ready), 32'h1);
        check("midrst_locked", 32'(locked), 32'h0);
        check("midrst_underflow", 32'(underflow_cnt), 32'h0);
        check("midrst_sync_err", 32'(sync_err_cnt), 32'h0);
        check("midrst_pixel_data", 32'(bus.pixel_data), 32'(FILL));
        tick();
        rst = 1'b0;
        tick();
        check("postrst_level", 32'(level), 32'h0);
        check("postrst_s_ready", 32'(bus.s_ready), 32'h1);
        req(11'd0, 11'd0);
        check("postrst_pixel", 32'(bus.pixel_data), 32'(FILL));
        check("postrst_locked", 32'(locked), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
